// File: rtl/shift_rot_if.sv
// Handshake bundle for the shift/rotate pipeline.
// The producer and consumer side uses the master modport.
// The shift unit itself uses the slave modport.
interface shift_rot_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic [WIDTH-1:0] in_data;
    logic [7:0]       in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_cf;
    logic             out_cf_upd;
    logic [7:0]       out_tag;

    modport master (
        output in_valid, in_op, in_amt, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_cf, out_cf_upd, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_amt, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_cf, out_cf_upd, out_tag
    );
endinterface

// File: rtl/shift_rot_pipe.sv
// Pipelined shift/rotate unit with one register stage per log2 mux level.
// Right-going ops are bit-reversed on entry and on exit, so a single
// left-shift datapath serves every op. Stall is global: every stage
// advances together or every stage holds.
module shift_rot_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input logic        clk,
    input logic        rst,
    shift_rot_if.slave bus
);
    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
        return r;
    endfunction

    // Left shift by s; vacated low bits take either the wrapped top bits or the fill bit.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d, input int s,
                                                     input logic rot, input logic fill);
        logic [2*WIDTH-1:0] t;
        t = {d, (rot ? d : {WIDTH{fill}})} << s;
        return t[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic is_right(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SAR) || (op == OP_ROR);
    endfunction

    function automatic logic is_rot(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    logic             advance;

    // Entry-side values, before the first register stage
    logic             vld_p0;
    logic [2:0]       op_p0;
    logic [AMT_W-1:0] amt_p0;
    logic [WIDTH-1:0] data_p0;
    logic             sign_p0;
    logic             cf_p0;
    logic             upd_p0;
    logic [7:0]       tag_p0;
    logic             pass_p0;
    logic [AMT_W-1:0] neg_amt;
    logic [AMT_W-1:0] amt_m1;

    // Stage registers; the last stage keeps only valid plus the output registers
    logic             vld_p  [1:AMT_W];
    logic [2:0]       op_p   [1:AMT_W-1];
    logic [AMT_W-1:0] amt_p  [1:AMT_W-1];
    logic [WIDTH-1:0] data_p [1:AMT_W-1];
    logic             sign_p [1:AMT_W-1];
    logic             cf_p   [1:AMT_W-1];
    logic             upd_p  [1:AMT_W-1];
    logic [7:0]       tag_p  [1:AMT_W-1];

    logic [WIDTH-1:0] data_o;
    logic             cf_o;
    logic             upd_o;
    logic [7:0]       tag_o;

    // Source of each level: index 0 is the entry side, index k is stage register k
    logic             src_vld  [0:AMT_W-1];
    logic [2:0]       src_op   [0:AMT_W-1];
    logic [AMT_W-1:0] src_amt  [0:AMT_W-1];
    logic [WIDTH-1:0] src_data [0:AMT_W-1];
    logic             src_sign [0:AMT_W-1];
    logic             src_cf   [0:AMT_W-1];
    logic             src_upd  [0:AMT_W-1];
    logic [7:0]       src_tag  [0:AMT_W-1];
    logic [WIDTH-1:0] lvl_data [0:AMT_W-1];
    logic [WIDTH-1:0] fin_data;
    logic             fin_cf;

    assign advance        = ~vld_p[AMT_W] | bus.out_ready;
    assign bus.in_ready   = advance;
    assign bus.out_valid  = vld_p[AMT_W];
    assign bus.out_data   = data_o;
    assign bus.out_cf     = cf_o;
    assign bus.out_cf_upd = upd_o;
    assign bus.out_tag    = tag_o;

    // Entry decode: pass-through masking, shift carry from the original operand, reversal of right ops
    always_comb begin
        pass_p0 = bus.in_op > OP_ROR;
        upd_p0  = ~pass_p0 & (bus.in_amt != '0);
        neg_amt = '0 - bus.in_amt;
        amt_m1  = bus.in_amt - AMT_W'(1);
        cf_p0   = upd_p0 & ((bus.in_op == OP_SHL) ? bus.in_data[neg_amt] : bus.in_data[amt_m1]);
        vld_p0  = bus.in_valid;
        op_p0   = bus.in_op;
        amt_p0  = pass_p0 ? '0 : bus.in_amt;
        data_p0 = is_right(bus.in_op) ? bit_rev(bus.in_data) : bus.in_data;
        sign_p0 = bus.in_data[WIDTH-1];
        tag_p0  = bus.in_tag;
    end

    // Gather each level's source fields from the entry side or the previous stage
    always_comb begin
        src_vld[0]  = vld_p0;
        src_op[0]   = op_p0;
        src_amt[0]  = amt_p0;
        src_data[0] = data_p0;
        src_sign[0] = sign_p0;
        src_cf[0]   = cf_p0;
        src_upd[0]  = upd_p0;
        src_tag[0]  = tag_p0;
        for (int k = 1; k < AMT_W; k++) begin
            src_vld[k]  = vld_p[k];
            src_op[k]   = op_p[k];
            src_amt[k]  = amt_p[k];
            src_data[k] = data_p[k];
            src_sign[k] = sign_p[k];
            src_cf[k]   = cf_p[k];
            src_upd[k]  = upd_p[k];
            src_tag[k]  = tag_p[k];
        end
    end

    // Level k+1 shifts by 2^(AMT_W-1-k) when that amount bit is set
    always_comb begin
        for (int k = 0; k < AMT_W; k++) begin
            lvl_data[k] = src_amt[k][AMT_W-1-k]
                        ? shift_level(src_data[k], 1 << (AMT_W-1-k), is_rot(src_op[k]),
                                      (src_op[k] == OP_SAR) & src_sign[k])
                        : src_data[k];
        end
    end

    // Un-reverse right ops; rotate carry comes from bit 0 of the left-domain result
    always_comb begin
        fin_data = is_right(src_op[AMT_W-1]) ? bit_rev(lvl_data[AMT_W-1]) : lvl_data[AMT_W-1];
        fin_cf   = is_rot(src_op[AMT_W-1]) ? (lvl_data[AMT_W-1][0] & src_upd[AMT_W-1])
                                           : src_cf[AMT_W-1];
    end

    // Valid bits: cleared by reset, shifted together with the data on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= AMT_W; k++) vld_p[k] <= 1'b0;
        end else if (advance) begin
            for (int k = 1; k <= AMT_W; k++) vld_p[k] <= src_vld[k-1];
        end
    end

    // Intermediate data stages: no reset, move with the stream, bubbles included
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 1; k < AMT_W; k++) begin
                op_p[k]   <= src_op[k-1];
                amt_p[k]  <= src_amt[k-1];
                data_p[k] <= lvl_data[k-1];
                sign_p[k] <= src_sign[k-1];
                cf_p[k]   <= src_cf[k-1];
                upd_p[k]  <= src_upd[k-1];
                tag_p[k]  <= src_tag[k-1];
            end
        end
    end

    // Output stage registers: zero after reset, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
            cf_o   <= 1'b0;
            upd_o  <= 1'b0;
            tag_o  <= '0;
        end else if (advance) begin
            data_o <= fin_data;
            cf_o   <= fin_cf;
            upd_o  <= src_upd[AMT_W-1];
            tag_o  <= src_tag[AMT_W-1];
        end
    end
endmodule

// File: tb/tb_shift_rot_pipe.sv
// Directed bench for shift_rot_pipe at WIDTH=32: single-op latency and results,
// a stalled back-to-back stream, and reset with ops in flight.
module tb_shift_rot_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    shift_rot_if #(.WIDTH(W)) bus ();

    shift_rot_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stream table: op, amt, operand and hand-computed result / carry / update
    logic [2:0]   s_op  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd4, 3'd5, 3'd2};
    logic [4:0]   s_amt [10] = '{5'd4, 5'd4, 5'd8, 5'd8, 5'd8, 5'd31, 5'd16, 5'd1, 5'd7, 5'd1};
    logic [W-1:0] s_din [10] = '{32'h0000_00FF, 32'h0000_00FF, 32'hF000_0000, 32'h1234_5678,
                                 32'h1234_5678, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0003,
                                 32'hCAFE_F00D, 32'h7FFF_FFFF};
    logic [W-1:0] s_exp [10] = '{32'h0000_0FF0, 32'h0000_000F, 32'hFFF0_0000, 32'h3456_7812,
                                 32'h7812_3456, 32'h8000_0000, 32'h0000_FFFF, 32'h8000_0001,
                                 32'hCAFE_F00D, 32'h3FFF_FFFF};
    logic         s_cf  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         s_upd [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    logic [W-1:0] hold_data;
    logic [7:0]   hold_tag;
    logic         hold_cf;
    logic         hold_upd;
    int           in_idx;
    int           out_idx;
    int           seen;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [4:0] amt,
                          input logic [W-1:0] din, input logic [7:0] tag,
                          input logic [W-1:0] e_data, input logic e_cf, input logic e_upd);
        int lat;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_amt    = amt;
        bus.in_data   = din;
        bus.in_tag    = tag;
        bus.out_ready = 1'b1;
        #1 check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_data"}, 64'(bus.out_data), 64'(e_data));
        check({name, "_cf"}, 64'(bus.out_cf), 64'(e_cf));
        check({name, "_cf_upd"}, 64'(bus.out_cf_upd), 64'(e_upd));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        @(posedge clk);
        #1 check({name, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_amt    = '0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_cf", 64'(bus.out_cf), 64'd0);
        check("rst_out_cf_upd", 64'(bus.out_cf_upd), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed single ops
        run_op("shl1",     3'd0, 5'd1,  32'h8000_0001, 8'h11, 32'h0000_0002, 1'b1, 1'b1);
        run_op("sar31",    3'd2, 5'd31, 32'h8000_0000, 8'h12, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op("shr31",    3'd1, 5'd31, 32'h8000_0000, 8'h13, 32'h0000_0001, 1'b0, 1'b1);
        run_op("ror1",     3'd4, 5'd1,  32'h0000_0001, 8'h14, 32'h8000_0000, 1'b1, 1'b1);
        run_op("rol4",     3'd3, 5'd4,  32'h8000_0000, 8'h15, 32'h0000_0008, 1'b0, 1'b1);
        run_op("shl_amt0", 3'd0, 5'd0,  32'hDEAD_BEEF, 8'h16, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op("op7_pass", 3'd7, 5'd3,  32'hDEAD_BEEF, 8'h17, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Back-to-back stream with the consumer stalled for cycles 8..10
        in_idx  = 0;
        out_idx = 0;
        for (int c = 0; c < 60 && out_idx < 10; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 8 && c <= 10);
            bus.in_valid  = (in_idx < 10);
            if (in_idx < 10) begin
                bus.in_op   = s_op[in_idx];
                bus.in_amt  = s_amt[in_idx];
                bus.in_data = s_din[in_idx];
                bus.in_tag  = 8'(in_idx);
            end
            #1;
            if (c >= 8 && c <= 10) begin
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                if (c == 8) begin
                    hold_data = bus.out_data;
                    hold_tag  = bus.out_tag;
                    hold_cf   = bus.out_cf;
                    hold_upd  = bus.out_cf_upd;
                end else begin
                    check("stall_hold_data", 64'(bus.out_data), 64'(hold_data));
                    check("stall_hold_tag", 64'(bus.out_tag), 64'(hold_tag));
                    check("stall_hold_cf", 64'({bus.out_cf, bus.out_cf_upd}), 64'({hold_cf, hold_upd}));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                check("stream_tag", 64'(bus.out_tag), 64'(out_idx));
                check("stream_data", 64'(bus.out_data), 64'(s_exp[out_idx]));
                check("stream_cf", 64'(bus.out_cf), 64'(s_cf[out_idx]));
                check("stream_cf_upd", 64'(bus.out_cf_upd), 64'(s_upd[out_idx]));
                out_idx++;
            end
            if (bus.in_valid && bus.in_ready) in_idx++;
            @(posedge clk);
        end
        check("stream_count", 64'(out_idx), 64'd10);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen++;
        end
        check("stream_no_extra", 64'(seen), 64'd0);

        // Reset with three ops in flight and one offered during the reset edge
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_op    = 3'd0;
            bus.in_amt   = 5'(i + 1);
            bus.in_data  = 32'h0000_0001;
            bus.in_tag   = 8'(8'h20 + i);
        end
        @(negedge clk);
        rst         = 1'b1;
        bus.in_tag  = 8'h99;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        check("midrst_out_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);
        run_op("post_rst", 3'd0, 5'd8, 32'h0000_00AB, 8'h5A, 32'h0000_AB00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
